// File: rtl/dco_freq_lock_if.sv
// dco_freq_lock_if: control/status bundle between a loop supervisor and the
// DCO frequency-lock controller.
//
//   enable     supervisor -> lock : run the loop (low = hold code, idle)
//   target     supervisor -> lock : desired rising-edge count per window
//   dco_code   lock -> supervisor : code currently driven to the DCO
//   meas_count lock -> supervisor : edge count of the last completed window
//   meas_valid lock -> supervisor : one-cycle strobe for meas_count
//   locked     lock -> supervisor : loop is in lock
//   step_idx   lock -> supervisor : current speed index, 0..8
//   busy       lock -> supervisor : controller is not in IDLE
//   fsm_state  lock -> supervisor : raw FSM state (IDLE/GATE/EVAL/SETTLE)
//
// Handshake: meas_valid is a valid-only strobe with no ready. It is high for
// exactly one clk cycle per completed window, never two cycles in a row;
// meas_count is already updated while meas_valid is high and stays stable
// until the next strobe, so a consumer may capture it in that cycle or later.
interface dco_freq_lock_if;
    logic       enable;
    logic [7:0] target;
    logic [7:0] dco_code;
    logic [7:0] meas_count;
    logic       meas_valid;
    logic       locked;
    logic [3:0] step_idx;
    logic       busy;
    logic [1:0] fsm_state;

    modport master (
        output enable, target,
        input  dco_code, meas_count, meas_valid, locked, step_idx, busy, fsm_state
    );

    modport slave (
        input  enable, target,
        output dco_code, meas_count, meas_valid, locked, step_idx, busy, fsm_state
    );
endinterface

// File: rtl/dco_freq_lock.sv
// dco_freq_lock: frequency-lock loop for an 8-bit priority-coded DCO.
// Counts rising edges of dco_in over a GATE_CYCLES window, compares against
// bus.target +/- TOL and steps the speed index up or down. After LOCK_COUNT
// consecutive in-tolerance windows the locked flag is raised.
//
// Ports:
//   clk      system clock
//   resetnn  asynchronous, active-low reset
//   dco_in   DCO square wave, asynchronous to clk
//   bus      dco_freq_lock_if.slave (enable, target in; dco_code,
//            meas_count, meas_valid, locked, step_idx, busy, fsm_state out)
module dco_freq_lock #(
    parameter int GATE_CYCLES   = 256,
    parameter int TOL           = 1,
    parameter int LOCK_COUNT    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int INIT_STEP     = 4
) (
    input  logic             clk,
    input  logic             resetnn,
    input  logic             dco_in,
    dco_freq_lock_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATE   = 2'd1,
        EVAL   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    localparam logic [15:0] GATE_LAST   = 16'(GATE_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  LOCK_N      = 4'(LOCK_COUNT);
    localparam logic [3:0]  INIT_IDX    = 4'(INIT_STEP);
    localparam logic [8:0]  TOL9        = 9'(TOL);

    // Index 0 stops the DCO; index k selects the single bit 1 << (8-k).
    function automatic logic [7:0] code_of(input logic [3:0] k);
        if (k == 4'd0) return 8'h00;
        return 8'h01 << (4'd8 - k);
    endfunction

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  edge_cnt_q, edge_cnt_d;
    logic [7:0]  meas_count_q, meas_count_d;
    logic [3:0]  step_idx_q, step_idx_d;
    logic [7:0]  dco_code_q, dco_code_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic        locked_q, locked_d;

    logic        edge_seen;
    logic [8:0]  cnt9, tgt9, lo9, hi9;
    logic        too_slow, too_fast, step_up, step_dn, step_change;

    assign edge_seen = sync2_q & ~prev_q;

    // Window evaluation in 9 bits so target+TOL never wraps and target-TOL
    // floors at zero.
    always_comb begin
        cnt9        = {1'b0, edge_cnt_q};
        tgt9        = {1'b0, bus.target};
        lo9         = (tgt9 >= TOL9) ? (tgt9 - TOL9) : 9'd0;
        hi9         = tgt9 + TOL9;
        too_slow    = (cnt9 < lo9);
        too_fast    = (cnt9 > hi9);
        step_up     = too_slow && (step_idx_q != 4'd8);
        step_dn     = too_fast && (step_idx_q != 4'd0);
        step_change = step_up || step_dn;
    end

    // State register
    always_ff @(posedge clk or negedge resetnn) begin
        if (!resetnn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = GATE;
                GATE:    if (cnt_q == GATE_LAST) state_d = EVAL;
                EVAL:    state_d = step_change ? SETTLE : GATE;
                SETTLE:  if (cnt_q == SETTLE_LAST) state_d = GATE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.meas_valid = (state_q == EVAL);
        bus.fsm_state  = state_q;
    end

    // Datapath next values
    always_comb begin
        sync1_d = dco_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        // One counter serves both GATE and SETTLE; it restarts at 0 on every
        // state change so each phase begins from a clean count.
        if ((state_d == state_q) && ((state_q == GATE) || (state_q == SETTLE)))
            cnt_d = cnt_q + 16'd1;
        else
            cnt_d = 16'd0;

        // Counting only in GATE means the count is zero on the first GATE
        // cycle and holds the full window value during EVAL.
        if (state_q == GATE)
            edge_cnt_d = (edge_cnt_q == 8'hFF) ? 8'hFF : edge_cnt_q + {7'd0, edge_seen};
        else
            edge_cnt_d = 8'd0;

        // Load the result as the window closes so meas_count is already
        // valid during the EVAL cycle in which meas_valid is high.
        meas_count_d = meas_count_q;
        if ((state_q == GATE) && (state_d == EVAL))
            meas_count_d = edge_cnt_d;

        step_idx_d = step_idx_q;
        run_cnt_d  = run_cnt_q;
        locked_d   = locked_q;
        if (!bus.enable) begin
            run_cnt_d = 4'd0;
            locked_d  = 1'b0;
        end else if (state_q == EVAL) begin
            if (too_slow || too_fast) begin
                run_cnt_d = 4'd0;
                locked_d  = 1'b0;
                if (step_up)      step_idx_d = step_idx_q + 4'd1;
                else if (step_dn) step_idx_d = step_idx_q - 4'd1;
            end else begin
                if (run_cnt_q != LOCK_N) run_cnt_d = run_cnt_q + 4'd1;
                if (run_cnt_d == LOCK_N) locked_d = 1'b1;
            end
        end
        dco_code_d = code_of(step_idx_d);
    end

    always_ff @(posedge clk or negedge resetnn) begin
        if (!resetnn) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            cnt_q        <= 16'd0;
            edge_cnt_q   <= 8'd0;
            meas_count_q <= 8'd0;
            step_idx_q   <= INIT_IDX;
            dco_code_q   <= code_of(INIT_IDX);
            run_cnt_q    <= 4'd0;
            locked_q     <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            meas_count_q <= meas_count_d;
            step_idx_q   <= step_idx_d;
            dco_code_q   <= dco_code_d;
            run_cnt_q    <= run_cnt_d;
            locked_q     <= locked_d;
        end
    end

    assign bus.dco_code   = dco_code_q;
    assign bus.meas_count = meas_count_q;
    assign bus.step_idx   = step_idx_q;
    assign bus.locked     = locked_q;

endmodule
